// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the multi-cycle magnitude-compare sequencer.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Operand/result handshake bundle between an issuing stage and cmp_seq_ctrl.
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       res;
  logic             busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit magnitude comparator; msb_signed applies the
// two's-complement sign rule to the top bit of this slice.
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             msb_signed,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  always_comb begin
    eq = (x == y);
    // With differing sign bits the operand carrying the set MSB is the negative one.
    if (msb_signed && (x[SLICE-1] != y[SLICE-1])) begin
      gt = y[SLICE-1];
      lt = x[SLICE-1];
    end else begin
      gt = (x > y);
      lt = (x < y);
    end
  end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle magnitude compare: one SLICE-bit slice per cycle, most significant
// slice first, optionally finishing on the first unequal slice.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_seq_ctrl_if.slave bus
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam bit EARLY = (EARLY_EXIT != 0);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSL - 1);

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             sgn_reg, sgn_next;
  logic [1:0]       dec_reg, dec_next;   // {gt, lt} of the deciding slice, 00 = none yet
  logic [2:0]       res_reg, res_next;

  logic [SLICE-1:0] a_sl [NSL];
  logic [SLICE-1:0] b_sl [NSL];
  logic             sl_gt, sl_eq, sl_lt;

  for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
    assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
    assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
  end

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .x          (a_sl[idx_reg]),
    .y          (b_sl[idx_reg]),
    .msb_signed (sgn_reg && (idx_reg == IDX_TOP)),
    .gt         (sl_gt),
    .eq         (sl_eq),
    .lt         (sl_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      dec_reg   <= 2'b00;
      res_reg   <= RES_NONE;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      dec_reg   <= dec_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    dec_next   = dec_reg;
    res_next   = res_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.b;
          sgn_next   = bus.sgn;
          idx_next   = IDX_TOP;
          dec_next   = 2'b00;
          state_next = RUN;
        end
      end

      RUN: begin
        // Without early exit only the first (most significant) difference counts.
        if (!sl_eq && (EARLY || (dec_reg == 2'b00))) begin
          dec_next = {sl_gt, sl_lt};
        end
        if (EARLY && !sl_eq) begin
          res_next   = sl_gt ? RES_GT : RES_LT;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          if (dec_next == 2'b10) begin
            res_next = RES_GT;
          end else if (dec_next == 2'b01) begin
            res_next = RES_LT;
          end else begin
            res_next = RES_EQ;
          end
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          res_next   = RES_NONE;
          idx_next   = '0;
          state_next = IDLE;
        end
      end

      default: begin
        res_next   = RES_NONE;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == RUN) || (state_reg == DONE);
  assign bus.res       = res_reg;

endmodule
